// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared constants and types for the MNIST MLP datapath
package mnist_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 13;

  localparam int L0_IN = 784;
  localparam int L1_IN = 20;
  localparam int L2_IN = 20;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/valid_delay.sv
// rtl/valid_delay.sv - reset-clearable shift line delaying a valid flag by DEPTH cycles
module valid_delay
  import mnist_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  output logic delayed,
  output logic delayed_next
);

  logic [DEPTH-1:0] line;

  // delayed_next is the value delayed will take after the next edge,
  // so downstream registers can line up with it without an extra stage
  generate
    if (DEPTH == 1) begin : g_single
      // single-stage delay line
      always_ff @(posedge clk) begin
        if (reset) line <= '0;
        else       line <= valid;
      end
      assign delayed_next = valid;
    end else begin : g_multi
      // multi-stage delay line, oldest sample in the MSB
      always_ff @(posedge clk) begin
        if (reset) line <= '0;
        else       line <= {line[DEPTH-2:0], valid};
      end
      assign delayed_next = line[DEPTH-2];
    end
  endgenerate

  assign delayed = line[DEPTH-1];

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - walks one layer's fan-in and drives the neuron X/Active controls
module layer_sequencer #(
  parameter int N_IN    = 784,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = $clog2(N_IN)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] x_rdata,
  output logic [DATA_W-1:0] X,
  output logic              Active
);
  import mnist_pkg::*;

  // drain covers the last RAM read plus the MAC pipeline
  localparam int DRAIN_LEN = RD_LAT + MAC_LAT;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);
  localparam logic [ADDR_W-1:0]  K_LAST     = ADDR_W'(N_IN - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_LEN - 1);

  seq_state_t         state;
  logic [ADDR_W-1:0]  k;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               fetch_valid;
  logic               data_valid;
  logic               data_valid_next;

  assign fetch_valid = (state == FETCH);

  valid_delay #(
    .DEPTH (RD_LAT)
  ) u_valid_delay (
    .clk          (Clk),
    .reset        (Reset),
    .valid        (fetch_valid),
    .delayed      (data_valid),
    .delayed_next (data_valid_next)
  );

  // only the returned word for a fetched index reaches the neurons;
  // every other cycle feeds zero so drain-cycle products vanish
  assign X = data_valid ? x_rdata : '0;

  assign x_addr = k;
  assign w_addr = k;

  // pass sequencing with registered Busy/Done/Active
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      k         <= '0;
      drain_cnt <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Active    <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (data_valid_next) Active <= 1'b1;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= FETCH;
            k     <= '0;
            Busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (k == K_LAST) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            k <= k + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state  <= DONE;
            Busy   <= 1'b0;
            Active <= 1'b0;
            Done   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        DONE: begin
          if (Start) begin
            state <= FETCH;
            k     <= '0;
            Busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed self-checking bench for layer_sequencer
module tb_layer_sequencer;

  localparam int NB = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  // instance A: N_IN=4, RD_LAT=1, MAC_LAT=2
  logic        start_a, busy_a, done_a, active_a;
  logic [1:0]  xaddr_a, waddr_a;
  logic [15:0] xrd_a, x_a;
  logic signed [15:0] wrd_a;
  logic signed [15:0] wrom_a [4];
  longint prod_a = 0, acc_a = 0, z_a = 0;

  layer_sequencer #(.N_IN(4), .RD_LAT(1), .MAC_LAT(2)) dut_a (
    .Clk(clk), .Reset(reset), .Start(start_a), .Busy(busy_a), .Done(done_a),
    .x_addr(xaddr_a), .w_addr(waddr_a), .x_rdata(xrd_a), .X(x_a), .Active(active_a)
  );

  always @(posedge clk) begin
    xrd_a <= 16'(xaddr_a) + 16'd1;
    wrd_a <= wrom_a[waddr_a];
  end

  always @(posedge clk) begin
    if (!active_a) begin
      prod_a <= 0;
      acc_a  <= 0;
    end else begin
      prod_a <= longint'($signed(x_a)) * longint'(wrd_a);
      acc_a  <= acc_a + prod_a;
      z_a    <= (acc_a + prod_a) >>> 13;
    end
  end

  // instance B: default parameters
  logic        start_b, busy_b, done_b, active_b;
  logic [9:0]  xaddr_b, waddr_b;
  logic [15:0] xrd_b, x_b;
  logic signed [15:0] wrd_b;
  logic signed [15:0] xmem_b [NB];
  logic signed [15:0] wmem_b [NB];
  longint prod_b = 0, acc_b = 0, z_b = 0;

  layer_sequencer dut_b (
    .Clk(clk), .Reset(reset), .Start(start_b), .Busy(busy_b), .Done(done_b),
    .x_addr(xaddr_b), .w_addr(waddr_b), .x_rdata(xrd_b), .X(x_b), .Active(active_b)
  );

  always @(posedge clk) begin
    xrd_b <= xmem_b[xaddr_b];
    wrd_b <= wmem_b[waddr_b];
  end

  always @(posedge clk) begin
    if (!active_b) begin
      prod_b <= 0;
      acc_b  <= 0;
    end else begin
      prod_b <= longint'($signed(x_b)) * longint'(wrd_b);
      acc_b  <= acc_b + prod_b;
      z_b    <= (acc_b + prod_b) >>> 13;
    end
  end

  // instance C: N_IN=4, RD_LAT=2, MAC_LAT=3
  logic        start_c, busy_c, done_c, active_c;
  logic [1:0]  xaddr_c, waddr_c;
  logic [15:0] r1_c, xrd_c, x_c;

  layer_sequencer #(.N_IN(4), .RD_LAT(2), .MAC_LAT(3)) dut_c (
    .Clk(clk), .Reset(reset), .Start(start_c), .Busy(busy_c), .Done(done_c),
    .x_addr(xaddr_c), .w_addr(waddr_c), .x_rdata(xrd_c), .X(x_c), .Active(active_c)
  );

  always @(posedge clk) begin
    r1_c  <= 16'(xaddr_c) + 16'd1;
    xrd_c <= r1_c;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one pass on A, checked cycle by cycle; optionally re-pulse Start mid-pass
  task automatic run_a(input bit repulse, input string name);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("%s_busy_c%0d", name, c), busy_a, (c <= 6));
      check($sformatf("%s_active_c%0d", name, c), active_a, (c >= 1 && c <= 6));
      check($sformatf("%s_done_c%0d", name, c), done_a, (c == 7));
      check($sformatf("%s_x_c%0d", name, c), x_a, (c >= 1 && c <= 4) ? c : 0);
      if (c <= 3) check($sformatf("%s_addr_c%0d", name, c), xaddr_a, c);
      start_a = repulse && (c == 2 || c == 5);
      @(negedge clk);
    end
    start_a = 1'b0;
    check($sformatf("%s_z", name), z_a, 14);
  endtask

  initial begin
    longint gsum;
    int first_act, act_cnt, done_cyc, cyc, nd;

    wrom_a[0] = 16'sd8192;
    wrom_a[1] = 16'sd16384;
    wrom_a[2] = -16'sd8192;
    wrom_a[3] = 16'sd24576;
    gsum = 0;
    for (int k = 0; k < NB; k++) begin
      xmem_b[k] = 16'((((k * 37) % 200) - 100) * 50);
      wmem_b[k] = 16'((((k * 53) % 300) - 150) * 20);
      gsum += longint'(xmem_b[k]) * longint'(wmem_b[k]);
    end

    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_active", active_a, 0);
    check("rst_x", x_a, 0);
    check("rst_xaddr", xaddr_a, 0);
    check("rst_waddr", waddr_a, 0);
    reset = 1'b0;
    @(negedge clk);

    run_a(1'b0, "basic");
    run_a(1'b1, "repulse");

    // Start held high: passes back-to-back every 8 cycles
    @(negedge clk) start_a = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 24; c++) begin
      check($sformatf("held_done_c%0d", c), done_a, ((c % 8) == 7));
      check($sformatf("held_active_c%0d", c), active_a, ((c % 8) >= 1 && (c % 8) <= 6));
      if (c == 22) start_a = 1'b0;
      @(negedge clk);
    end
    check("held_idle_busy", busy_a, 0);
    check("held_z", z_a, 14);

    // reset in cycle 3 of a pass
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy_a, 0);
    check("midrst_active", active_a, 0);
    check("midrst_x", x_a, 0);
    check("midrst_done", done_a, 0);
    reset = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_a(1'b0, "after_rst");

    // full-size layer against a golden dot product
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    first_act = -1;
    act_cnt = 0;
    done_cyc = -1;
    cyc = 0;
    while (done_cyc < 0 && cyc < 2000) begin
      if (active_b) begin
        if (first_act < 0) first_act = cyc;
        act_cnt++;
      end
      if (done_b) done_cyc = cyc;
      cyc++;
      @(negedge clk);
    end
    check("big_first_active", first_act, 1);
    check("big_active_cnt", act_cnt, 786);
    check("big_done_cycle", done_cyc, 787);
    check("big_z", z_b, gsum >>> 13);
    repeat (5) @(negedge clk);
    check("big_z_hold", z_b, gsum >>> 13);
    check("big_busy_after", busy_b, 0);

    // longer latencies
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("lat_busy_c%0d", c), busy_c, (c <= 8));
      check($sformatf("lat_active_c%0d", c), active_c, (c >= 2 && c <= 8));
      check($sformatf("lat_done_c%0d", c), done_c, (c == 9));
      check($sformatf("lat_x_c%0d", c), x_c, (c >= 2 && c <= 5) ? c - 1 : 0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
